// File: rtl/bram_stream_reader_pkg.sv
// Shared definitions for the bram stream reader.
//   state_e     : reader FSM state encoding
//   FifoDepth   : depth of the output skid FIFO; also the read credit limit
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StDrain = 2'd2
    } state_e;

    localparam int unsigned FifoDepth = 2;

endpackage

// File: rtl/bram_stream_fifo2.sv
// Two-entry FIFO holding {last, data} beats for the stream output.
// Push and pop in the same cycle are allowed. The head entry drives the stream
// directly, so it stays stable while it is not popped.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   push_i       : write push_data_i at the tail
//   push_data_i  : {last, data}
//   pop_i        : remove the head (only meaningful while valid_o=1)
//   valid_o      : FIFO holds at least one entry
//   head_o       : head entry
//   count_o      : number of entries held (0..2)
module bram_stream_fifo2 #(
    parameter int unsigned Width = 17
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [Width-1:0] head_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d = push_data_i;
                end else begin
                    tail_d = push_data_i;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                head_d  = tail_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                // Count is unchanged; the new entry lands behind whatever remains.
                if (count_q == 2'd1) begin
                    head_d = push_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = push_data_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != 2'd0);
    assign head_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side bram client: on start, reads len words from base through the bram
// read port and streams them on a valid/ready interface with last_o on the
// final word. Hides the one-cycle bram latency and reissues reads lost to a
// same-cycle bram write.
// Optional feature macro BRAM_STREAM_READER_LOOP_EN adds loop_i: when high as
// the final word of a pass issues, reading restarts from base.
//   clk_i, rst_i           : clock, asynchronous active-high reset
//   start_i, base_i, len_i : transfer request (ignored while busy_o)
//   busy_o, done_o         : transfer in progress / completion pulse
//   bram_read_o, bram_raddr_o, bram_write_i, bram_data_i : bram read port
//   data_o, valid_o, ready_i, last_o : output stream
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int unsigned memSize_p   = 8,
    parameter int unsigned dataWidth_p = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [memSize_p-1:0]   base_i,
    input  logic [memSize_p:0]     len_i,
`ifdef BRAM_STREAM_READER_LOOP_EN
    input  logic                   loop_i,
`endif
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   bram_read_o,
    output logic [memSize_p-1:0]   bram_raddr_o,
    input  logic                   bram_write_i,
    input  logic [dataWidth_p-1:0] bram_data_i,
    output logic [dataWidth_p-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic                   last_o
);

    state_e                 state_q, state_d;
    logic [memSize_p-1:0]   addr_q, addr_d;
    logic [memSize_p-1:0]   base_q, base_d;
    logic [memSize_p:0]     remain_q, remain_d;
    logic [memSize_p:0]     len_q, len_d;
    logic                   inflight_q, inflight_d;
    logic                   inflight_last_q, inflight_last_d;
    logic                   zero_done_q, zero_done_d;

    logic [1:0]             fifo_count;
    logic [dataWidth_p:0]   fifo_head;
    logic                   pop;
    logic [2:0]             occ;
    logic                   credit_ok;
    logic                   issue;
    logic                   issue_last;
    logic                   final_pop;
    logic                   loop_now;

`ifdef BRAM_STREAM_READER_LOOP_EN
    assign loop_now = loop_i;
`else
    assign loop_now = 1'b0;
`endif

    assign pop        = valid_o & ready_i;
    // Words buffered or on their way from the bram.
    assign occ        = {1'b0, fifo_count} + {2'b00, inflight_q};
    assign credit_ok  = (occ - {2'b00, pop}) < 3'(FifoDepth);
    assign bram_read_o  = (state_q == StRead) & credit_ok;
    assign bram_raddr_o = addr_q;
    // A read coinciding with a bram write is lost and must be reissued.
    assign issue      = bram_read_o & ~bram_write_i;
    assign issue_last = issue & (remain_q == (memSize_p + 1)'(1));
    // In DRAIN nothing more issues, so the last word with nothing behind it
    // is the final word of the final pass.
    assign final_pop  = (state_q == StDrain) & pop & last_o & (occ == 3'd1);

    assign busy_o = (state_q != StIdle);
    assign done_o = final_pop | zero_done_q;

    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        base_d          = base_q;
        remain_d        = remain_q;
        len_d           = len_q;
        zero_done_d     = 1'b0;
        inflight_d      = issue;
        inflight_last_d = issue_last;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (len_i == '0) begin
                        zero_done_d = 1'b1;
                    end else begin
                        state_d  = StRead;
                        addr_d   = base_i;
                        base_d   = base_i;
                        remain_d = len_i;
                        len_d    = len_i;
                    end
                end
            end
            StRead: begin
                if (issue) begin
                    addr_d   = addr_q + 1'b1;
                    remain_d = remain_q - 1'b1;
                    if (issue_last) begin
                        if (loop_now) begin
                            addr_d   = base_q;
                            remain_d = len_q;
                        end else begin
                            state_d = StDrain;
                        end
                    end
                end
            end
            StDrain: begin
                if (final_pop) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            base_q          <= '0;
            remain_q        <= '0;
            len_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            zero_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            base_q          <= base_d;
            remain_q        <= remain_d;
            len_q           <= len_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            zero_done_q     <= zero_done_d;
        end
    end

    // Bram data is valid the cycle after an uncollided read.
    bram_stream_fifo2 #(
        .Width(dataWidth_p + 1)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (inflight_q),
        .push_data_i ({inflight_last_q, bram_data_i}),
        .pop_i       (pop),
        .valid_o     (valid_o),
        .head_o      (fifo_head),
        .count_o     (fifo_count)
    );

    assign last_o = fifo_head[dataWidth_p];
    assign data_o = fifo_head[dataWidth_p-1:0];

endmodule

// File: tb/tb_bram_stream_reader.sv
// Self-checking bench for bram_stream_reader: a behavioural bram, a queue of
// expected beats built from base/len, and per-cycle checks of addresses,
// beats, back-pressure stability, buffering bound, busy and done.
module tb_bram_stream_reader;

    localparam int unsigned M     = 8;
    localparam int unsigned W     = 16;
    localparam int unsigned Depth = 256;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [M-1:0] base_i;
    logic [M:0]   len_i;
    logic         loop_i;
    logic         busy, done, bram_read, bram_write, valid, ready, last;
    logic [M-1:0] raddr;
    logic [W-1:0] bram_data, data;

    logic [W-1:0] mem [Depth];
    int unsigned  checks = 0;
    int unsigned  errors = 0;

    always #5 clk = ~clk;

    bram_stream_reader #(
        .memSize_p  (M),
        .dataWidth_p(W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .base_i       (base_i),
        .len_i        (len_i),
`ifdef BRAM_STREAM_READER_LOOP_EN
        .loop_i       (loop_i),
`endif
        .busy_o       (busy),
        .done_o       (done),
        .bram_read_o  (bram_read),
        .bram_raddr_o (raddr),
        .bram_write_i (bram_write),
        .bram_data_i  (bram_data),
        .data_o       (data),
        .valid_o      (valid),
        .ready_i      (ready),
        .last_o       (last)
    );

    // Bram with write priority: a colliding read returns junk.
    always @(posedge clk or posedge rst) begin
        if (rst) bram_data <= '0;
        else if (bram_read && !bram_write) bram_data <= mem[raddr];
        else if (bram_read && bram_write) bram_data <= 16'hDEAD;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // rmode: 0 ready high, 1 random ready, 2 ready low cycles 3-5
    // wmode: 0 no writes, 1 random writes, 2 write on cycle 2
    task automatic run_xfer(input int base, input int len, input int passes,
                            input int rmode, input int wmode, input bit chk_lat);
        logic [W:0] exp_q[$];
        logic [W:0] held;
        int  total = len * passes;
        int  issued = 0, beats = 0, collided = 0, done_cnt = 0;
        int  done_cyc = -1, first_valid = -1, first_read = -1;
        bit  hold = 1'b0, finished = 1'b0;
        for (int p = 0; p < passes; p++)
            for (int k = 0; k < len; k++)
                exp_q.push_back({k == len - 1, mem[(base + k) % Depth]});
        @(posedge clk); #1;
        start = 1'b1; base_i = M'(base); len_i = (M + 1)'(len);
        ready = 1'b1; bram_write = 1'b0; loop_i = 1'b0;
        for (int cyc = 1; cyc <= 3000 && !finished; cyc++) begin
            @(posedge clk); #1;
            start = 1'b0;
            case (rmode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: ready = !(cyc >= 3 && cyc <= 5);
            endcase
            case (wmode)
                0: bram_write = 1'b0;
                1: bram_write = ($urandom_range(0, 3) == 0);
                default: bram_write = (cyc == 2);
            endcase
            loop_i = (issued < total - len);
            // Junk start requests while busy must be ignored.
            if (rmode == 1 && busy && $urandom_range(0, 5) == 0) begin
                start = 1'b1; base_i = M'($urandom); len_i = (M + 1)'($urandom);
            end
            @(negedge clk);
            if (done_cyc >= 0) begin
                check_eq("busy_fall", busy, 0);
                finished = 1'b1;
            end else begin
                if (len != 0) check_eq("busy", busy, 1);
                if (bram_read) begin
                    if (first_read < 0) first_read = cyc;
                    if (bram_write) collided++;
                    else begin
                        check_eq("raddr", raddr,
                                 len != 0 ? (base + issued % len) % Depth : 0);
                        issued++;
                    end
                end
                if (hold) begin
                    check_eq("hold_valid", valid, 1);
                    check_eq("hold_data", {last, data}, held);
                end
                if (valid && first_valid < 0) first_valid = cyc;
                if (valid && ready) begin
                    if (exp_q.size() == 0) check_eq("extra_beat", beats + 1, total);
                    else check_eq("beat", {last, data}, exp_q.pop_front());
                    beats++;
                end
                hold = valid && !ready;
                held = {last, data};
                check_eq("buffered_le2", (issued - beats) <= 2, 1);
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                    check_eq("done_at_end", beats, total);
                end
            end
        end
        start = 1'b0; ready = 1'b1; bram_write = 1'b0; loop_i = 1'b0;
        if (!finished) check_eq("timeout", finished, 1);
        check_eq("beats", beats, total);
        check_eq("issued", issued, total);
        check_eq("done_cnt", done_cnt, 1);
        if (len == 0) begin
            check_eq("zero_done_cyc", done_cyc, 1);
            check_eq("zero_reads", first_read, -1);
        end
        if (wmode == 2) check_eq("collided", collided, 1);
        if (chk_lat) begin
            check_eq("first_read", first_read, 1);
            check_eq("first_valid", first_valid, 3);
            check_eq("done_cyc", done_cyc, 6);
        end
    endtask

    initial begin
        for (int i = 0; i < Depth; i++) mem[i] = W'($urandom);
        rst = 1'b1; start = 1'b0; base_i = '0; len_i = '0;
        ready = 1'b1; bram_write = 1'b0; loop_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_read", bram_read, 0);
        check_eq("rst_valid", valid, 0);
        check_eq("rst_last", last, 0);
        check_eq("rst_data", data, 0);
        rst = 1'b0;

        run_xfer(16'h10, 4, 1, 0, 0, 1);
        run_xfer(16'h10, 4, 1, 2, 0, 0);
        run_xfer(16'h10, 4, 1, 0, 2, 0);
        run_xfer(16'hFE, 4, 1, 0, 0, 0);
        run_xfer(5, 0, 1, 0, 0, 0);

        // Reset with a read in flight.
        @(posedge clk); #1;
        start = 1'b1; base_i = 8'h20; len_i = 9'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_read", bram_read, 0);
        check_eq("mid_rst_valid", valid, 0);
        check_eq("mid_rst_data", data, 0);
        check_eq("mid_rst_last", last, 0);
        check_eq("mid_rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_xfer(16'h20, 8, 1, 0, 0, 0);

        for (int t = 0; t < 12; t++)
            run_xfer(int'($urandom_range(0, 255)), int'($urandom_range(0, 40)), 1, 1, 1, 0);
        run_xfer(int'($urandom_range(0, 255)), 256, 1, 1, 1, 0);

`ifdef BRAM_STREAM_READER_LOOP_EN
        run_xfer(16'h30, 2, 3, 0, 0, 0);
        run_xfer(16'hFF, 3, 3, 1, 1, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
